j1_uart: RTL and testbench
==========================

Name: j1_uart

Overview:
- Memory-mapped UART peripheral on the j1 CPU I/O bus, directly downstream of the core.
- Consumes the core's I/O write strobe, address and write data, and returns read data on the core's io_din input.
- Provides a byte transmitter and a receiver with a 4-entry RX FIFO.
- Software polls a status register; there are no interrupts.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per serial bit (12 MHz / 115200). Must be ≥ 4.
- FIFO_DEPTH_LOG2, 2: log2 of the RX FIFO depth (4 entries).

Ports:
- clk  input  1  system clock, shared with j1.
- resetq  input  1  reset, synchronous, active-low.
- io_addr  input  16  I/O address (core top-of-stack).
- io_rd  input  1  I/O read strobe, one cycle, qualifies io_addr.
- io_wr  input  1  I/O write strobe from j1, one cycle.
- io_wdata  input  16  write data (j1 dout); only [7:0] used.
- io_rdata  output  16  read data to j1 io_din; combinational from io_addr and registers.
- uart_rx  input  1  serial in, asynchronous, idles high.
- uart_tx  output  1  serial out, idles high.

Behaviour:
- Register map:
  - io_addr[12]=1: DATA. Write loads a TX byte; read returns {8'h00, RX FIFO head}.
  - io_addr[13]=1: STATUS. Read returns {12'h0, ferr, ovr, rx_valid, tx_ready}; writes are ignored.
  - Both bits set: DATA takes priority.
  - Any other address: io_rdata = 0, strobes ignored.
- Reset (resetq=0 at a clk edge):
  - uart_tx=1, TX FSM IDLE, RX FSM IDLE.
  - FIFO empty; ovr=0, ferr=0; tx_ready=1; io_rdata reflects reset state.
  - A reset mid-frame aborts it; uart_tx is high on the next cycle.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - DATA write with tx_ready=1: byte latched, tx_ready=0 on the next cycle, uart_tx=0 on the next cycle.
  - Frame: start bit 0, 8 bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
  - Bit counter runs 0..7; baud counter runs 0..CLKS_PER_BIT-1 and reloads on every state change.
  - tx_ready returns to 1 on the cycle after STOP completes, i.e. 10*CLKS_PER_BIT cycles after the write edge.
  - DATA write while tx_ready=0: silently dropped; the frame in progress is unaffected.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: on a synchronized 1→0 edge, go to START.
  - START: at CLKS_PER_BIT/2 (integer division), resample. If high (glitch), return to IDLE with no flag. If low, go to DATA.
  - DATA: sample 8 bits at bit centres, every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample at centre. If 1, push the byte. If 0, set ferr (sticky) and discard the byte. Then IDLE.
  - The next start edge is accepted from the cycle after the stop sample.
- RX FIFO (circular, pointers wrap modulo depth):
  - Read of DATA with io_rd=1 and non-empty: pops at that clk edge; io_rdata shows the pre-pop head during that cycle.
  - Read of DATA when empty: returns 0, no pop, pointers unchanged.
  - Push when full: byte dropped, ovr set (sticky).
  - Pop and push in the same cycle when full: both happen, no overrun, count unchanged.
  - Pop and push in the same cycle when empty: the push succeeds and the pop is ignored.
  - rx_valid = non-empty.
- STATUS read with io_rd=1 clears ovr and ferr at that edge. The read returns the pre-clear values. A flag set in the same cycle takes priority over the clear, so it remains set.
- io_wr and io_rd together on the same address: both actions are taken.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Reset, then STATUS read → io_rdata=16'h0001; uart_tx=1 held for 100 cycles.
- Write DATA=16'h1255 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles; tx_ready=0 for 80 cycles, then 1. A second write issued at cycle 20 is dropped: no second frame appears.
- Drive RX frame 0xA5 at 8 cycles/bit → rx_valid=1 after the stop sample. DATA read returns 16'h00A5 and pops; the next STATUS read returns 16'h0001.
- Send 5 frames (0x01..0x05) with no reads → STATUS=16'h0007 (ovr set). Four DATA reads return 01, 02, 03, 04; a fifth read returns 0 with rx_valid=0. A STATUS read then returns 16'h0001.
- Frame with stop bit 0 → ferr set, no push, STATUS=16'h0009. A 2-cycle low glitch on uart_rx → no push and no flags.
- FIFO full; a DATA read coincides with the 5th stop-sample push → no ovr, 4 entries remain, order preserved. Assert resetq low mid-TX frame → uart_tx=1 and tx_ready=1 on the next cycle.

Source files
------------

// File: rtl/j1_uart.sv
// j1_uart: memory-mapped UART for the j1 CPU I/O bus.
//
// Register map (decoded from io_addr):
//   io_addr[12]=1 : DATA   write -> transmit byte, read -> {8'h00, RX FIFO head} (pops on io_rd)
//   io_addr[13]=1 : STATUS read  -> {12'h0, ferr, ovr, rx_valid, tx_ready} (io_rd clears ferr/ovr)
//   both set      : DATA wins; any other address reads as 0 and ignores strobes.
//
// Ports:
//   clk, resetq        system clock, synchronous active-low reset
//   io_addr, io_rd     address and one-cycle read strobe from the core
//   io_wr, io_wdata    one-cycle write strobe and write data (only [7:0] used)
//   io_rdata           combinational read data to the core's io_din
//   uart_rx, uart_tx   serial lines, both idle high
//
// Bus handshake: there is no back-pressure. A strobe is acted on at the clk
// edge where it is high; io_rdata is valid in the same cycle as io_rd.
// Writes to DATA while the transmitter is busy are dropped.
module j1_uart #(
  parameter int CLKS_PER_BIT    = 104,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [15:0] io_addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // Address decode
  logic sel_data, sel_stat;
  assign sel_data = io_addr[12];
  assign sel_stat = io_addr[13] & ~io_addr[12];

  logic unused_bits;
  assign unused_bits = &{1'b0, io_addr[15:14], io_addr[11:0], io_wdata[15:8]};

  // ---------------- Transmitter ----------------
  uart_state_e    tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_line_q, tx_line_d;
  logic           tx_ready, tx_start;

  assign tx_ready = (tx_state_q == ST_IDLE);
  assign tx_start = io_wr & sel_data & tx_ready;
  assign uart_tx  = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      ST_IDLE: if (tx_start) begin
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_data_d  = io_wdata[7:0];
      end
      ST_START: if (tx_cnt_q == BAUD_LAST) begin
        tx_state_d = ST_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = 3'd0;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      ST_DATA: if (tx_cnt_q == BAUD_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      ST_STOP: if (tx_cnt_q == BAUD_LAST) begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = '0;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level follows the next state so the output is a clean flop.
    case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_data_d[tx_bit_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------- Receiver ----------------
  // rx_s1/rx_s2 synchronize; rx_s3 is one cycle of history for edge detection.
  logic           rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e    rx_state_q, rx_state_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_push, rx_ferr_set;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (rx_s3_q & ~rx_s2_q) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
      end
      // Half a bit in: a line that is high again was a glitch, not a start bit.
      ST_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      ST_DATA: if (rx_cnt_q == BAUD_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      ST_STOP: if (rx_cnt_q == BAUD_LAST) begin
        rx_cnt_d    = '0;
        rx_state_d  = ST_IDLE;
        rx_push     = rx_s2_q;
        rx_ferr_set = ~rx_s2_q;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- RX FIFO and flags ----------------
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          fifo_empty, fifo_full, pop, push_ok, stat_rd;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = io_rd & sel_data & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = rx_push & (~fifo_full | pop);
  assign stat_rd    = io_rd & sel_stat;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok & ~pop)      count_d = count_q + 1'b1;
    else if (~push_ok & pop) count_d = count_q - 1'b1;
    // A flag raised this cycle beats the clear-on-read.
    ovr_d  = (rx_push & fifo_full & ~pop) | (ovr_q & ~stat_rd);
    ferr_d = rx_ferr_set | (ferr_q & ~stat_rd);
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetq && push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------- Read mux ----------------
  always_comb begin
    io_rdata = 16'h0000;
    if (sel_data)      io_rdata = {8'h00, fifo_empty ? 8'h00 : mem_q[rd_ptr_q]};
    else if (sel_stat) io_rdata = {12'h000, ferr_q, ovr_q, ~fifo_empty, tx_ready};
  end

endmodule

// File: tb/tb_j1_uart.sv
// Self-checking bench for j1_uart with CLKS_PER_BIT=8.
module tb_j1_uart;
  localparam int N = 8;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;
  localparam logic [1:0] OP_RXF = 2'd0, OP_RD = 2'd1, OP_PEEK = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        stop;
    logic [15:0] exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetq;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        io_rd, io_wr, uart_rx, uart_tx;

  always #5 clk = ~clk;

  j1_uart #(.CLKS_PER_BIT(N), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .resetq(resetq), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_rx(input logic v, input int n);
    uart_rx = v;
    repeat (n) step();
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    io_rd = 1'b1;
    #1;
    d = io_rdata;
    step();
    io_rd = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
    io_addr = 16'h0000;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] data);
    io_addr = a;
    io_wdata = data;
    io_wr = 1'b1;
    step();
    io_wr = 1'b0;
    io_addr = 16'h0000;
  endtask

  // Drives one frame. With rd_at_stop set, a DATA read is issued in the cycle
  // whose edge takes the stop sample, so the pop and the push coincide.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic rd_at_stop, input logic [7:0] exp_head);
    hold_rx(1'b0, N);
    for (int i = 0; i < 8; i++) hold_rx(b[i], N);
    if (!rd_at_stop) begin
      hold_rx(stop, N);
    end else begin
      uart_rx = stop;
      repeat (N - 2) step();
      io_addr = A_DATA;
      io_rd = 1'b1;
      #1;
      check("pop_at_push", io_rdata, {8'h00, exp_head});
      step();
      io_rd = 1'b0;
      io_addr = 16'h0000;
      step();
    end
    uart_rx = 1'b1;
    repeat (3) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] d;
    logic        idle_ok;
    logic        exp_tx;
    logic [7:0]  tx_byte;

    // Reset
    resetq = 1'b0; io_addr = 16'h0000; io_rd = 1'b0; io_wr = 1'b0;
    io_wdata = 16'h0000; uart_rx = 1'b1;
    repeat (3) step();
    resetq = 1'b1;
    check("reset_tx", {15'h0, uart_tx}, 16'h0001);
    peek(A_STAT, d);
    check("reset_status_peek", d, 16'h0001);
    rd_reg(A_STAT, d);
    check("reset_status_read", d, 16'h0001);
    idle_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (uart_tx !== 1'b1) idle_ok = 1'b0;
      step();
    end
    check("tx_idle_100", {15'h0, idle_ok}, 16'h0001);

    // Transmit 0x55; a second write at cycle 20 must be dropped
    tx_byte = 8'h55;
    wr_reg(A_DATA, 16'h1255);
    for (int c = 0; c < 100; c++) begin
      io_addr = A_STAT;
      if (c == 20) io_wr = 1'b0;
      #1;
      if (c >= 80)      exp_tx = 1'b1;
      else if (c < 8)   exp_tx = 1'b0;
      else if (c >= 72) exp_tx = 1'b1;
      else              exp_tx = tx_byte[c / 8 - 1];
      check($sformatf("tx_line_c%0d", c), {15'h0, uart_tx}, {15'h0, exp_tx});
      check($sformatf("tx_ready_c%0d", c), {15'h0, io_rdata[0]}, {15'h0, (c >= 80)});
      if (c == 19) begin
        io_addr = A_DATA;
        io_wdata = 16'h0000;
        io_wr = 1'b1;
      end
      step();
    end
    io_addr = 16'h0000;

    // Table-driven RX / register vectors
    vecs.push_back('{OP_RXF,  16'h0000, 8'hA5, 1'b1, 16'h0000});
    vecs.push_back('{OP_PEEK, 16'h0000, 8'h00, 1'b1, 16'h0000});
    vecs.push_back('{OP_PEEK, 16'h3000, 8'h00, 1'b1, 16'h00A5});
    vecs.push_back('{OP_PEEK, A_STAT,   8'h00, 1'b1, 16'h0003});
    vecs.push_back('{OP_RD,   A_DATA,   8'h00, 1'b1, 16'h00A5});
    vecs.push_back('{OP_RD,   A_STAT,   8'h00, 1'b1, 16'h0001});
    for (int i = 1; i <= 5; i++) vecs.push_back('{OP_RXF, 16'h0000, 8'(i), 1'b1, 16'h0000});
    vecs.push_back('{OP_RD,   A_STAT,   8'h00, 1'b1, 16'h0007});
    for (int i = 1; i <= 4; i++) vecs.push_back('{OP_RD, A_DATA, 8'h00, 1'b1, 16'(i)});
    vecs.push_back('{OP_RD,   A_DATA,   8'h00, 1'b1, 16'h0000});
    vecs.push_back('{OP_PEEK, A_STAT,   8'h00, 1'b1, 16'h0001});
    vecs.push_back('{OP_RD,   A_STAT,   8'h00, 1'b1, 16'h0001});
    vecs.push_back('{OP_RXF,  16'h0000, 8'h3C, 1'b0, 16'h0000});
    vecs.push_back('{OP_RD,   A_STAT,   8'h00, 1'b1, 16'h0009});
    vecs.push_back('{OP_PEEK, A_STAT,   8'h00, 1'b1, 16'h0001});
    vecs.push_back('{OP_PEEK, A_DATA,   8'h00, 1'b1, 16'h0000});

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RXF: send_frame(vecs[i].data, vecs[i].stop, 1'b0, 8'h00);
        OP_RD: begin
          rd_reg(vecs[i].addr, d);
          check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
        end
        default: begin
          peek(vecs[i].addr, d);
          check($sformatf("vec%0d_peek", i), d, vecs[i].exp);
        end
      endcase
    end

    // Two-cycle low glitch: no byte, no flags
    hold_rx(1'b0, 2);
    hold_rx(1'b1, 20);
    peek(A_STAT, d);
    check("glitch_status", d, 16'h0001);

    // Full FIFO; a DATA read coincides with the fifth push
    send_frame(8'h11, 1'b1, 1'b0, 8'h00);
    send_frame(8'h22, 1'b1, 1'b0, 8'h00);
    send_frame(8'h33, 1'b1, 1'b0, 8'h00);
    send_frame(8'h44, 1'b1, 1'b0, 8'h00);
    peek(A_STAT, d);
    check("full_status", d, 16'h0003);
    send_frame(8'h55, 1'b1, 1'b1, 8'h11);
    peek(A_STAT, d);
    check("coincide_status", d, 16'h0003);
    rd_reg(A_DATA, d); check("coincide_rd22", d, 16'h0022);
    rd_reg(A_DATA, d); check("coincide_rd33", d, 16'h0033);
    rd_reg(A_DATA, d); check("coincide_rd44", d, 16'h0044);
    rd_reg(A_DATA, d); check("coincide_rd55", d, 16'h0055);
    peek(A_STAT, d);
    check("coincide_empty", d, 16'h0001);

    // Reset in the middle of a TX frame (byte 0xF0: data bit 2 is 0)
    wr_reg(A_DATA, 16'h00F0);
    repeat (30) step();
    check("midframe_tx", {15'h0, uart_tx}, 16'h0000);
    peek(A_STAT, d);
    check("midframe_busy", d, 16'h0000);
    resetq = 1'b0;
    step();
    check("abort_tx", {15'h0, uart_tx}, 16'h0001);
    peek(A_STAT, d);
    check("abort_status", d, 16'h0001);
    resetq = 1'b1;
    idle_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (uart_tx !== 1'b1) idle_ok = 1'b0;
      step();
    end
    check("abort_idle", {15'h0, idle_ok}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
